// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } pipe_state_e;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Steps the five-stage pipeline: one fetch (plus optional data access) per step,
// freezing the pipeline registers until the bus side reports completion.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dm_need,
  input  logic             im_done,
  input  logic             dm_done,
  input  logic             load_use,
  input  logic             branch_taken,
  output logic             im_start,
  output logic             dm_start,
  output logic             cpu_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TO_LAST = WC_W'(TIMEOUT - 1);

  pipe_state_e     state, state_next;
  logic            im_pend, dm_pend;
  logic            adv;
  logic            wait_inc, wait_clr;
  logic [WC_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= BOOT;
    else
      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    adv         = 1'b0;
    im_start    = 1'b0;
    dm_start    = 1'b0;
    cpu_stall   = 1'b1;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    case (state)
      BOOT: state_next = ISSUE;
      ISSUE: begin
        im_start   = 1'b1;
        dm_start   = dm_need;
        state_next = WAIT;
      end
      WAIT: begin
        // A done arriving this cycle counts immediately, so the step ends without a latency bubble.
        adv       = (!im_pend || im_done) && (!dm_pend || dm_done);
        cpu_stall = !adv;
        if (adv) begin
          state_next = ISSUE;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_write   = 1'b1;
          end else if (load_use) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_pend <= 1'b0;
      dm_pend <= 1'b0;
    end else if (state == ISSUE) begin
      im_pend <= 1'b1;
      dm_pend <= dm_need;
    end else if (state == WAIT) begin
      if (im_done)
        im_pend <= 1'b0;
      if (dm_done)
        dm_pend <= 1'b0;
    end
  end

  assign wait_clr = (state == ISSUE);
  assign wait_inc = (state == WAIT) && !adv;

  sat_counter #(.W(WC_W)) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (wait_inc),
    .clr  (wait_clr),
    .count(wait_cnt)
  );

  // Flag is raised on the same edge that brings wait_cnt up to TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout_err <= 1'b0;
    else if ((TIMEOUT != 0) && wait_inc && (wait_cnt == TO_LAST))
      timeout_err <= 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cpu_stall),
    .clr  (1'b0),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a per-cycle vector table for the normal stepping
// flows, then hand sequences for timeout, counter saturation and mid-transaction reset.
module tb_pipe_stall_ctrl;

  localparam int TO = 8;
  localparam int CW = 8;
  localparam int STALL_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          dm_need, im_done, dm_done, load_use, branch_taken;
  logic          im_start, dm_start, cpu_stall, pc_write, ifid_write;
  logic          idex_bubble, ifid_flush, idex_flush, timeout_err;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .dm_need     (dm_need),
    .im_done     (im_done),
    .dm_done     (dm_done),
    .load_use    (load_use),
    .branch_taken(branch_taken),
    .im_start    (im_start),
    .dm_start    (dm_start),
    .cpu_stall   (cpu_stall),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .timeout_err (timeout_err),
    .stall_cycles(stall_cycles)
  );

  // Output bit order: im_start dm_start cpu_stall pc_write ifid_write idex_bubble ifid_flush idex_flush timeout_err
  typedef struct {
    string      name;
    logic       dm_need;
    logic       im_done;
    logic       dm_done;
    logic       load_use;
    logic       branch_taken;
    logic [8:0] want;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [8:0] outs();
    return {im_start, dm_start, cpu_stall, pc_write, ifid_write,
            idex_bubble, ifid_flush, idex_flush, timeout_err};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic dn, input logic id,
                                input logic dd, input logic lu, input logic bt,
                                input logic [8:0] want);
    dm_need      = dn;
    im_done      = id;
    dm_done      = dd;
    load_use     = lu;
    branch_taken = bt;
    #1;
    check_output({name, " outs"}, 32'(outs()), 32'(want));
    check_output({name, " stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    @(posedge clk);
    #1;
    if (want[6] && exp_stall < STALL_MAX)
      exp_stall++;
  endtask

  initial begin
    vecs[0]  = '{"boot",           0, 0, 0, 0, 0, 9'b001000000};
    vecs[1]  = '{"s1_issue",       0, 0, 0, 0, 0, 9'b101000000};
    vecs[2]  = '{"s1_w1",          0, 0, 0, 0, 0, 9'b001000000};
    vecs[3]  = '{"s1_w2",          0, 0, 0, 0, 0, 9'b001000000};
    vecs[4]  = '{"s1_w3",          0, 0, 0, 0, 0, 9'b001000000};
    vecs[5]  = '{"s1_adv",         0, 1, 0, 0, 0, 9'b000110000};
    vecs[6]  = '{"s2_issue",       1, 0, 0, 0, 0, 9'b111000000};
    vecs[7]  = '{"s2_w1",          0, 0, 0, 0, 0, 9'b001000000};
    vecs[8]  = '{"s2_w2_dmdone",   0, 0, 1, 0, 0, 9'b001000000};
    vecs[9]  = '{"s2_w3",          0, 0, 0, 0, 0, 9'b001000000};
    vecs[10] = '{"s2_w4",          0, 0, 0, 0, 0, 9'b001000000};
    vecs[11] = '{"s2_w5_imdone",   0, 1, 0, 0, 0, 9'b000110000};
    vecs[12] = '{"s3_issue",       1, 0, 0, 1, 0, 9'b111000000};
    vecs[13] = '{"s3_both_lu",     0, 1, 1, 1, 0, 9'b000001000};
    vecs[14] = '{"s4_refetch",     0, 0, 0, 0, 0, 9'b101000000};
    vecs[15] = '{"s4_branch_lu",   0, 1, 0, 1, 1, 9'b000100110};
    vecs[16] = '{"s5_issue_stray", 0, 1, 1, 0, 0, 9'b101000000};
    vecs[17] = '{"s5_w1_dmstray",  0, 0, 1, 0, 0, 9'b001000000};
    vecs[18] = '{"s5_w2_adv",      0, 1, 0, 0, 0, 9'b000110000};

    rst          = 1'b1;
    dm_need      = 1'b0;
    im_done      = 1'b0;
    dm_done      = 1'b0;
    load_use     = 1'b0;
    branch_taken = 1'b0;
    #1;
    check_output("reset outs", 32'(outs()), 32'(9'b001000000));
    check_output("reset stall_cycles", 32'(stall_cycles), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 19; i++)
      apply_stimulus(vecs[i].name, vecs[i].dm_need, vecs[i].im_done, vecs[i].dm_done,
                     vecs[i].load_use, vecs[i].branch_taken, vecs[i].want);

    // Bus never answers: the flag must rise after TO wait cycles and the FSM must keep waiting.
    apply_stimulus("to_issue", 0, 0, 0, 0, 0, 9'b101000000);
    for (int k = 1; k <= 20; k++)
      apply_stimulus($sformatf("to_wait%0d", k), 0, 0, 0, 0, 0,
                     (k > TO) ? 9'b001000001 : 9'b001000000);
    apply_stimulus("to_done", 0, 1, 0, 0, 0, 9'b000110001);

    // Long stall drives the narrow stall counter into saturation.
    apply_stimulus("sat_issue", 0, 0, 0, 0, 0, 9'b101000001);
    for (int k = 1; k <= 240; k++)
      apply_stimulus($sformatf("sat_wait%0d", k), 0, 0, 0, 0, 0, 9'b001000001);
    apply_stimulus("sat_done", 0, 1, 0, 0, 0, 9'b000110001);
    check_output("sat_final stall_cycles", 32'(stall_cycles), 32'(STALL_MAX));

    // Reset with a data access still pending; the stale dm_done lands in BOOT.
    apply_stimulus("rs_issue", 1, 0, 0, 0, 0, 9'b111000001);
    apply_stimulus("rs_w1_im", 0, 1, 0, 0, 0, 9'b001000001);
    dm_need = 1'b0;
    im_done = 1'b0;
    rst     = 1'b1;
    #1;
    check_output("rs_during outs", 32'(outs()), 32'(9'b001000000));
    check_output("rs_during stall_cycles", 32'(stall_cycles), 32'd0);
    exp_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus("rs_boot_stale", 0, 0, 1, 0, 0, 9'b001000000);
    apply_stimulus("rs_issue2", 0, 0, 0, 0, 0, 9'b101000000);
    apply_stimulus("rs_w1_adv", 0, 1, 0, 0, 0, 9'b000110000);
    apply_stimulus("rs_next", 0, 0, 0, 0, 0, 9'b101000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
